mips32_load_ctrl: RTL
=====================

MIPS32_LOAD_CTRL -- requirements
Module: mips32_load_ctrl

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- WORD_LEN, 32, data word width.
- MEM_CELL_SIZE, 8, memory cell (byte) width.
- INSTR_MEM_SIZE, 1024, instruction memory cells.
- DATA_MEM_SIZE, 1024, data memory cells.
- REG_FILE_SIZE, 32, register count.
- RST_CYCLES, 8, CPU reset hold cycles.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1, sole clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- ld_valid, in, 1, load word offered.
- ld_ready, out, 1, load word accepted this cycle if ld_valid.
- ld_sel, in, 1, 0 = instruction memory, 1 = data memory.
- ld_addr, in, 32, byte address of word.
- ld_data, in, WORD_LEN, word to load.
- ld_err, out, 1, one-cycle pulse: offered word rejected.
- mem_we_i / mem_we_d, out, 1 each, cell write strobe per memory.
- mem_waddr, out, 32, cell address.
- mem_wdata, out, MEM_CELL_SIZE, cell data.
- start, in, 1, begin CPU reset/run sequence.
- cpu_rst, out, 1, reset to pipeline.
- running, out, 1, CPU released.
- dump_req, in, 1, request register-file snapshot.
- rf_raddr, out, $clog2(REG_FILE_SIZE), register read address.
- rf_rdata, in, WORD_LEN, combinational register read data.
- dump_valid, out, 1, snapshot word present.
- dump_ready, in, 1, consumer accepts.
- dump_idx, out, $clog2(REG_FILE_SIZE), register index of dump_data.
- dump_data, out, WORD_LEN, register value.
- dump_done, out, 1, one-cycle pulse after last register accepted.
REQ-003 Reset SHALL be synchronous and active-high on rst; single clock clk.

Function
REQ-004 FSM states SHALL be IDLE, WRITE, HOLD, RUN, DUMP.
REQ-005 ld_ready SHALL be 1 only in IDLE; a word transfers when ld_valid && ld_ready.
REQ-006 An accepted word with ld_addr not a multiple of WORD_LEN/MEM_CELL_SIZE, or with ld_addr+cells-1 >= selected memory size, SHALL be dropped with ld_err=1 the next cycle; FSM stays IDLE.
REQ-007 A valid accepted word SHALL enter WRITE and emit N=WORD_LEN/MEM_CELL_SIZE cell writes, one per cycle, big-endian: cycle k writes ld_data[WORD_LEN-1-k*MEM_CELL_SIZE -: MEM_CELL_SIZE] to ld_addr+k; then return to IDLE.
REQ-008 Exactly one of mem_we_i/mem_we_d (per the ld_sel latched at acceptance) SHALL be high during each WRITE cycle; both SHALL be 0 otherwise.
REQ-009 start SHALL be sampled only in IDLE; elsewhere it SHALL be ignored. If start and ld_valid are both high in IDLE, the load SHALL take priority and start SHALL be ignored.
REQ-010 HOLD SHALL last exactly RST_CYCLES cycles with cpu_rst=1, then enter RUN.
REQ-011 cpu_rst SHALL be 0 only in RUN and DUMP; running SHALL be 1 in RUN and DUMP.
REQ-012 dump_req SHALL be sampled only in RUN; it SHALL enter DUMP with index 0.
REQ-013 In DUMP, rf_raddr SHALL equal the current index. dump_data/dump_idx SHALL be registered from rf_rdata/rf_raddr. dump_valid SHALL be held, with dump_data/dump_idx stable, until dump_ready.
REQ-014 Each dump_valid&&dump_ready SHALL advance the index. After index REG_FILE_SIZE-1 is accepted, the block SHALL pulse dump_done and return to RUN; the index SHALL NOT wrap further.
REQ-015 Accepted dump word order SHALL be 0..REG_FILE_SIZE-1, with no gaps or duplicates, under arbitrary dump_ready stalls.

Reset
REQ-016 On rst, from any state: FSM to IDLE; cpu_rst=1; running=0; ld_ready=0 that cycle; ld_err, mem_we_i, mem_we_d, dump_valid, dump_done = 0; index=0.
REQ-017 rst during WRITE or DUMP SHALL abandon the operation; no further cell writes or dump words SHALL be issued.

Verification
REQ-018 Load sel=0, addr=0x4, data=0x8C220010 -> mem_we_i on 4 consecutive cycles: addr 4..7, data 0x8C,0x22,0x00,0x10; ld_ready low for those 4 cycles.
REQ-019 Load sel=1, addr=0x2 -> ld_err pulse, no write strobe. Load addr=DATA_MEM_SIZE-2 -> ld_err pulse, no write strobe.
REQ-020 start in IDLE -> cpu_rst=1 for 8 cycles, then cpu_rst=0, running=1. start during WRITE -> ignored.
REQ-021 RUN + dump_req, rf_rdata=idx*3, dump_ready toggling every cycle -> 32 words idx 0..31 with data 0..93, then dump_done once.
REQ-022 rst asserted mid-DUMP at idx 10 -> next cycle IDLE, cpu_rst=1, dump_valid=0, no dump_done.

Source files
------------

// File: rtl/mips32_load_ctrl_if.sv
// Bus bundle for the MIPS32 loader / reset sequencer / register-dump block.
// master = environment side (loader, CPU, dump consumer); slave = mips32_load_ctrl.
interface mips32_load_ctrl_if #(
   parameter int WORD_LEN      = 32,
   parameter int MEM_CELL_SIZE = 8,
   parameter int REG_FILE_SIZE = 32
);
   localparam int IDX_W = $clog2(REG_FILE_SIZE);

   logic                     ld_valid;
   logic                     ld_ready;
   logic                     ld_sel;
   logic [31:0]              ld_addr;
   logic [WORD_LEN-1:0]      ld_data;
   logic                     ld_err;

   logic                     mem_we_i;
   logic                     mem_we_d;
   logic [31:0]              mem_waddr;
   logic [MEM_CELL_SIZE-1:0] mem_wdata;

   logic                     start;
   logic                     cpu_rst;
   logic                     running;

   logic                     dump_req;
   logic [IDX_W-1:0]         rf_raddr;
   logic [WORD_LEN-1:0]      rf_rdata;
   logic                     dump_valid;
   logic                     dump_ready;
   logic [IDX_W-1:0]         dump_idx;
   logic [WORD_LEN-1:0]      dump_data;
   logic                     dump_done;

   modport master (
      output ld_valid, ld_sel, ld_addr, ld_data, start, dump_req, rf_rdata, dump_ready,
      input  ld_ready, ld_err, mem_we_i, mem_we_d, mem_waddr, mem_wdata,
             cpu_rst, running, rf_raddr, dump_valid, dump_idx, dump_data, dump_done
   );

   modport slave (
      input  ld_valid, ld_sel, ld_addr, ld_data, start, dump_req, rf_rdata, dump_ready,
      output ld_ready, ld_err, mem_we_i, mem_we_d, mem_waddr, mem_wdata,
             cpu_rst, running, rf_raddr, dump_valid, dump_idx, dump_data, dump_done
   );
endinterface

// File: rtl/mips32_load_ctrl.sv
// Program loader for a MIPS32 core: splits words into big-endian memory cells,
// sequences CPU reset/release, and streams a register-file snapshot out.
module mips32_load_ctrl #(
   parameter int WORD_LEN       = 32,
   parameter int MEM_CELL_SIZE  = 8,
   parameter int INSTR_MEM_SIZE = 1024,
   parameter int DATA_MEM_SIZE  = 1024,
   parameter int REG_FILE_SIZE  = 32,
   parameter int RST_CYCLES     = 8
) (
   input  logic               clk,
   input  logic               rst,
   mips32_load_ctrl_if.slave  bus
);
   localparam int                CELLS     = WORD_LEN / MEM_CELL_SIZE;
   localparam int                IDX_W     = $clog2(REG_FILE_SIZE);
   localparam logic [31:0]       CELLS_W   = 32'(CELLS);
   localparam logic [31:0]       IMEM_LAST = 32'(INSTR_MEM_SIZE - CELLS);
   localparam logic [31:0]       DMEM_LAST = 32'(DATA_MEM_SIZE - CELLS);
   localparam logic [31:0]       WR_LAST   = 32'(CELLS - 1);
   localparam logic [31:0]       HOLD_LAST = 32'(RST_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REG_FILE_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      HOLD,
      RUN,
      DUMP
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                err_q, err_d;
   logic                dvalid_q, dvalid_d;
   logic                done_q, done_d;

   logic                sel_q, sel_d;
   logic [31:0]         addr_q, addr_d;
   logic [WORD_LEN-1:0] data_q, data_d;
   logic [WORD_LEN-1:0] ddata_q, ddata_d;
   logic [IDX_W-1:0]    didx_q, didx_d;

   logic                ld_ready;
   logic                ld_fire;
   logic                ld_bad;
   logic [31:0]         mem_last;

   assign ld_ready = (state_q == IDLE) && !rst;
   assign ld_fire  = bus.ld_valid && ld_ready;

   // Range test is written as addr > size-cells so that addresses near 2^32 cannot wrap.
   assign mem_last = bus.ld_sel ? DMEM_LAST : IMEM_LAST;
   assign ld_bad   = ((bus.ld_addr % CELLS_W) != 32'd0) || (bus.ld_addr > mem_last);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      err_d    = 1'b0;
      dvalid_d = dvalid_q;
      done_d   = 1'b0;
      sel_d    = sel_q;
      addr_d   = addr_q;
      data_d   = data_q;
      ddata_d  = ddata_q;
      didx_d   = didx_q;

      case (state_q)
         IDLE: begin
            if (ld_fire) begin
               if (ld_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = WRITE;
                  cnt_d   = 32'd0;
                  sel_d   = bus.ld_sel;
                  addr_d  = bus.ld_addr;
                  data_d  = bus.ld_data;
               end
            end else if (bus.start) begin
               state_d = HOLD;
               cnt_d   = 32'd0;
            end
         end

         // The word is shifted left so the next big-endian cell is always on top.
         WRITE: begin
            addr_d = addr_q + 32'd1;
            data_d = data_q << MEM_CELL_SIZE;
            cnt_d  = cnt_q + 32'd1;
            if (cnt_q == WR_LAST) begin
               state_d = IDLE;
            end
         end

         HOLD: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (bus.dump_req) begin
               state_d  = DUMP;
               idx_d    = '0;
               dvalid_d = 1'b0;
            end
         end

         // Capture a word when the output slot is empty, then hold it until accepted.
         DUMP: begin
            if (!dvalid_q) begin
               ddata_d  = bus.rf_rdata;
               didx_d   = idx_q;
               dvalid_d = 1'b1;
            end else if (bus.dump_ready) begin
               dvalid_d = 1'b0;
               if (idx_q == IDX_LAST) begin
                  done_d  = 1'b1;
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 32'd0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         dvalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
         dvalid_q <= dvalid_d;
         done_q   <= done_d;
      end
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ddata_q <= ddata_d;
      didx_q  <= didx_d;
   end

   // Outputs are also gated by rst so a reset cycle never issues strobes or handshakes.
   assign bus.ld_ready   = ld_ready;
   assign bus.ld_err     = err_q && !rst;
   assign bus.mem_we_i   = (state_q == WRITE) && !sel_q && !rst;
   assign bus.mem_we_d   = (state_q == WRITE) &&  sel_q && !rst;
   assign bus.mem_waddr  = addr_q;
   assign bus.mem_wdata  = data_q[WORD_LEN-1 -: MEM_CELL_SIZE];
   assign bus.running    = ((state_q == RUN) || (state_q == DUMP)) && !rst;
   assign bus.cpu_rst    = !bus.running;
   assign bus.rf_raddr   = idx_q;
   assign bus.dump_valid = (state_q == DUMP) && dvalid_q && !rst;
   assign bus.dump_idx   = didx_q;
   assign bus.dump_data  = ddata_q;
   assign bus.dump_done  = done_q && !rst;

   a_one_we : assert property (@(posedge clk) !(bus.mem_we_i && bus.mem_we_d));

   a_dump_hold : assert property (@(posedge clk) disable iff (rst)
      (bus.dump_valid && !bus.dump_ready) |=>
         (bus.dump_valid && $stable(bus.dump_data) && $stable(bus.dump_idx)));

   a_ready_idle : assert property (@(posedge clk)
      bus.ld_ready |-> (state_q == IDLE));
endmodule
